// File: rtl/instruction_fetch_arbiter_pkg.sv
// Shared definitions for the instruction fetch arbiter: bus widths, arbiter
// status encodings and the line-alignment helper.
package instruction_fetch_arbiter_pkg;

    localparam int AddressBusWidth           = 32;
    localparam int InstructionCacheLineWidth = 128;

    typedef enum logic [1:0] {
        ArbStatus_Idle = 2'd0,
        ArbStatus_Busy = 2'd1,
        ArbStatus_Done = 2'd2
    } arb_status_e;

    localparam logic [AddressBusWidth-1:0] LineOffsetMask = 'hF;

    // Downstream fetches are always whole lines, so the byte offset is dropped.
    function automatic logic [AddressBusWidth-1:0] line_align(input logic [AddressBusWidth-1:0] addr);
        return addr & ~LineOffsetMask;
    endfunction

endpackage

// File: rtl/instruction_fetch_arbiter_if.sv
// Requester and downstream memory signals of the instruction fetch arbiter.
// Handshake: a requester raises RequestN with a stable AddressN and holds both
// until it sees WaitN=0 for one cycle, when Line carries its data; the arbiter
// holds MemRequest/MemAddress until it samples MemWait=0, when MemLine is taken.
interface instruction_fetch_arbiter_if;
    import instruction_fetch_arbiter_pkg::*;

    logic                                 Request0;
    logic [AddressBusWidth-1:0]           Address0;
    logic                                 Wait0;
    logic                                 Request1;
    logic [AddressBusWidth-1:0]           Address1;
    logic                                 Wait1;
    logic [InstructionCacheLineWidth-1:0] Line;
    logic                                 MemRequest;
    logic [AddressBusWidth-1:0]           MemAddress;
    logic                                 MemWait;
    logic [InstructionCacheLineWidth-1:0] MemLine;
    logic                                 Owner;
    arb_status_e                          ArbState;

    modport slave (
        input  Request0, Address0, Request1, Address1, MemWait, MemLine,
        output Wait0, Wait1, Line, MemRequest, MemAddress, Owner, ArbState
    );

    modport master (
        output Request0, Address0, Request1, Address1, MemWait, MemLine,
        input  Wait0, Wait1, Line, MemRequest, MemAddress, Owner, ArbState
    );

endinterface

// File: rtl/instruction_fetch_arbiter_select.sv
// Winner selection for the fetch arbiter. INSTRUCTION_FETCH_ARBITER_ROUND_ROBIN_EN
// selects round-robin on ties (ptr_i names the favoured requester); otherwise requester 0 wins.
module fetch_arb_select (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       grant_o
);

`ifdef INSTRUCTION_FETCH_ARBITER_ROUND_ROBIN_EN
    assign grant_o = (req_i == 2'b11) ? ptr_i : req_i[1];
`else
    logic unused_ptr;
    assign unused_ptr = ptr_i;
    assign grant_o    = req_i[1] & ~req_i[0];
`endif

endmodule

// File: rtl/instruction_fetch_arbiter.sv
// Two-requester instruction line fetch arbiter: IDLE/BUSY/DONE FSM and datapath.
// Tie-break policy comes from fetch_arb_select (INSTRUCTION_FETCH_ARBITER_ROUND_ROBIN_EN).
module instruction_fetch_arbiter
    import instruction_fetch_arbiter_pkg::*;
(
    input logic                        clock,
    input logic                        reset,
    instruction_fetch_arbiter_if.slave bus
);

    arb_status_e                          state_q, state_d;
    logic                                 mem_request_q, mem_request_d;
    logic [AddressBusWidth-1:0]           mem_address_q, mem_address_d;
    logic [InstructionCacheLineWidth-1:0] line_q, line_d;
    logic                                 owner_q, owner_d;
    logic                                 ptr_q, ptr_d;
    logic                                 grant;

    fetch_arb_select u_select (
        .req_i   ({bus.Request1, bus.Request0}),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        state_d       = state_q;
        mem_request_d = mem_request_q;
        mem_address_d = mem_address_q;
        line_d        = line_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        case (state_q)
            ArbStatus_Idle: begin
                if (!bus.MemWait && (bus.Request0 || bus.Request1)) begin
                    state_d       = ArbStatus_Busy;
                    mem_request_d = 1'b1;
                    mem_address_d = line_align(grant ? bus.Address1 : bus.Address0);
                    owner_d       = grant;
                    ptr_d         = ~grant;
                end
            end
            ArbStatus_Busy: begin
                // Requests are not looked at here: a dropped request still completes.
                if (!bus.MemWait) begin
                    state_d       = ArbStatus_Done;
                    mem_request_d = 1'b0;
                    line_d        = bus.MemLine;
                end
            end
            ArbStatus_Done: state_d = ArbStatus_Idle;
            default:        state_d = ArbStatus_Idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ArbStatus_Idle;
            mem_request_q <= 1'b0;
            mem_address_q <= '0;
            line_q        <= '0;
            owner_q       <= 1'b0;
            ptr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_request_q <= mem_request_d;
            mem_address_q <= mem_address_d;
            line_q        <= line_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
        end
    end

    assign bus.Wait0      = bus.Request0 & ~((state_q == ArbStatus_Done) & ~owner_q);
    assign bus.Wait1      = bus.Request1 & ~((state_q == ArbStatus_Done) &  owner_q);
    assign bus.Line       = line_q;
    assign bus.MemRequest = mem_request_q;
    assign bus.MemAddress = mem_address_q;
    assign bus.Owner      = owner_q;
    assign bus.ArbState   = state_q;

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// Self-checking bench for instruction_fetch_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level arbitration model.
module tb_instruction_fetch_arbiter;
    import instruction_fetch_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // Transaction-level model state
    logic        req [2];
    logic [31:0] addr [2];
    logic        rr_pref;
    logic [127:0] last_line;
    int          last_owner;
    bit          in_done;
    int          exp_seq [4];

    instruction_fetch_arbiter_if bus ();

    instruction_fetch_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive();
        bus.Request0 = req[0];
        bus.Request1 = req[1];
        bus.Address0 = addr[0];
        bus.Address1 = addr[1];
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic wait_of(input int n);
        return (n == 1) ? bus.Wait1 : bus.Wait0;
    endfunction

    // One arbitration: optional new requests, s cycles of blocked issue, b cycles of busy downstream.
    task automatic do_round(input logic nr0, input logic nr1, input logic [31:0] na0,
                            input logic [31:0] na1, input int s, input int b, input logic drop_busy);
        int w;
        logic [127:0] data;
        if (nr0 && !req[0]) begin req[0] = 1'b1; addr[0] = na0; end
        if (nr1 && !req[1]) begin req[1] = 1'b1; addr[1] = na1; end
        bus.MemWait = 1'b0;
        drive();
        if (in_done) begin
            step();
            chk("done_no_issue", bus.MemRequest, 1'b0);
        end
        in_done = 1'b0;
        chk("line_hold", bus.Line, last_line);
        repeat (s) begin
            bus.MemWait = 1'b1;
            step();
            chk("blocked_issue", bus.MemRequest, 1'b0);
            chk("blocked_wait0", bus.Wait0, req[0]);
        end
        bus.MemWait = 1'b0;
        if (req[0] && req[1]) begin
`ifdef INSTRUCTION_FETCH_ARBITER_ROUND_ROBIN_EN
            w = rr_pref ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = req[1] ? 1 : 0;
        end
        rr_pref = (w == 0);
        step();
        chk("issue_req", bus.MemRequest, 1'b1);
        chk("issue_addr", bus.MemAddress, addr[w] & 32'hFFFF_FFF0);
        chk("issue_owner", bus.Owner, w[0]);
        chk("busy_wait", wait_of(w), 1'b1);
        if (drop_busy) begin
            req[w] = 1'b0;
            drive();
        end
        repeat (b) begin
            bus.MemWait = 1'b1;
            step();
            chk("busy_hold_req", bus.MemRequest, 1'b1);
            chk("busy_hold_wait", wait_of(w), req[w]);
        end
        data = {$urandom, $urandom, $urandom, $urandom};
        bus.MemLine = data;
        bus.MemWait = 1'b0;
        step();
        chk("done_line", bus.Line, data);
        chk("done_req", bus.MemRequest, 1'b0);
        chk("done_wait_owner", wait_of(w), 1'b0);
        chk("done_wait_other", wait_of(1 - w), req[1 - w]);
        last_line  = data;
        last_owner = w;
        bus.MemLine = ~data;
        req[w] = 1'b0;
        drive();
        in_done = 1'b1;
    endtask

    initial begin
        logic r0, r1;
        reset = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0;
        addr[0] = '0;  addr[1] = '0;
        drive();
        bus.MemWait = 1'b0;
        bus.MemLine = '0;
        rr_pref   = 1'b0;
        last_line = '0;
        last_owner = 0;
        in_done   = 1'b0;

        // Reset state, with requester 0 asserting during reset
        step();
        req[0] = 1'b1;
        drive();
        step();
        chk("reset_wait0", bus.Wait0, 1'b1);
        chk("reset_wait1", bus.Wait1, 1'b0);
        req[0] = 1'b0;
        drive();
        reset = 1'b0;
        chk("reset_memreq", bus.MemRequest, 1'b0);
        chk("reset_memaddr", bus.MemAddress, 32'h0);
        chk("reset_line", bus.Line, 128'h0);
        chk("reset_owner", bus.Owner, 1'b0);
        chk("reset_state", bus.ArbState, ArbStatus_Idle);

        // Reset in the middle of a transaction abandons it
        req[1] = 1'b1;
        addr[1] = 32'h0000_0048;
        drive();
        step();
        chk("rst_busy_req", bus.MemRequest, 1'b1);
        chk("rst_busy_owner", bus.Owner, 1'b1);
        reset = 1'b1;
        bus.MemLine = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE;
        step();
        chk("rst_abort_req", bus.MemRequest, 1'b0);
        chk("rst_abort_line", bus.Line, 128'h0);
        chk("rst_abort_owner", bus.Owner, 1'b0);
        chk("rst_abort_addr", bus.MemAddress, 32'h0);
        chk("rst_abort_wait1", bus.Wait1, 1'b1);
        reset = 1'b0;
        req[1] = 1'b0;
        drive();
        rr_pref = 1'b0;
        step();
        chk("rst_after_line", bus.Line, 128'h0);
        chk("rst_after_req", bus.MemRequest, 1'b0);
        bus.MemLine = '0;

        // Single request, minimum latency, unaligned address
        do_round(1'b1, 1'b0, 32'h0000_1234, 32'h0, 0, 0, 1'b0);
        // Downstream busy for five cycles
        do_round(1'b1, 1'b0, 32'h0000_2008, 32'h0, 0, 5, 1'b0);
        // Downstream busy in IDLE blocks issue
        do_round(1'b1, 1'b0, 32'h0000_300F, 32'h0, 3, 0, 1'b0);
        // Requester 1 drops its request during BUSY
        do_round(1'b0, 1'b1, 32'h0, 32'h0000_4444, 0, 1, 1'b1);

        // Both requesters held
`ifdef INSTRUCTION_FETCH_ARBITER_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            do_round(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 0, 0, 1'b0);
            chk("grant_seq", 128'(last_owner), 128'(exp_seq[i]));
        end

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1 && !req[0] && !req[1]) r0 = 1'b1;
            do_round(r0, r1, $urandom, $urandom, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_arbiter.md
INSTRUCTION_FETCH_ARBITER -- requirements
Module: instruction_fetch_arbiter

Interface
REQ-001 SHALL have ports: clock  input  1  single clock, all state updates on posedge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high.
REQ-003 SHALL have: Request0  input  1  line-fetch request, requester 0 (instruction prefetch buffer).
REQ-004 SHALL have: Address0  input  AddressBusWidth(32)  line address, requester 0, held while Request0=1.
REQ-005 SHALL have: Wait0  output  1  requester 0 stall; 0 means Line valid for requester 0.
REQ-006 SHALL have: Request1, Address1, Wait1  same widths/meaning for requester 1 (secondary/branch-target prefetcher).
REQ-007 SHALL have: Line  output  InstructionCacheLineWidth(128)  returned line, shared by both requesters.
REQ-008 SHALL have: MemRequest  output  1; MemAddress  output  32  downstream line-fetch request/address.
REQ-009 SHALL have: MemWait  input  1  downstream busy; MemLine  input  128  downstream line data.
REQ-010 SHALL have: Owner  output  1  index of requester owning the current transaction.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE.
REQ-012 IDLE: when MemWait=0 and any Request asserted, SHALL pick winner, latch {Address[31:4],4'b0000} into MemAddress, set Owner, MemRequest=1, go BUSY next cycle.
REQ-013 IDLE with MemWait=1 SHALL issue nothing and stay in IDLE.
REQ-014 BUSY SHALL last at least one cycle; first BUSY cycle with MemWait=0 SHALL latch MemLine into Line, clear MemRequest, go DONE.
REQ-015 DONE SHALL last exactly one cycle, then IDLE; Line SHALL hold its value until the next completion.
REQ-016 WaitN SHALL be 0 when RequestN=0, 0 in DONE when Owner=N, else 1 whenever RequestN=1.
REQ-017 Minimum latency: request in IDLE at cycle t -> WaitN=0 at cycle t+2 given MemWait=0 at t and t+1.
REQ-018 Requester deasserting Request during BUSY SHALL NOT abort; transaction completes, data written to Line, no Wait pulse lost to other requester.
REQ-019 Addresses SHALL be line-aligned (bits 3:0 zero) on MemAddress regardless of input low bits.
REQ-020 Loser of simultaneous request SHALL be served in the next IDLE, before any new request from winner if ROUND_ROBIN_EN defined.
REQ-021 A request arriving in DONE SHALL be evaluated in the following IDLE cycle, not DONE.

Reset
REQ-022 reset=1 SHALL force at next posedge: state IDLE, MemRequest=0, MemAddress=0, Line=0, Owner=0, priority pointer=0.
REQ-023 reset mid-BUSY SHALL abandon the transaction; returning MemLine SHALL be ignored.
REQ-024 During and after reset, Wait0/Wait1 SHALL follow REQ-016 (1 if requesting).

Configuration
REQ-025 Macro INSTRUCTION_FETCH_ARBITER_ROUND_ROBIN_EN SHALL select arbitration.
REQ-026 Undefined: fixed priority, requester 0 always wins simultaneous requests.
REQ-027 Defined: 1-bit pointer; on simultaneous requests the requester not last granted wins; pointer updates on each grant; reset value favours requester 0.

Structure
REQ-028 State encodings (ArbStatus_Idle/Busy/Done) SHALL live in a shared definitions include alongside existing prefetch-status constants; AddressBusWidth, InstructionCacheLineWidth from the structure-parameter include.
REQ-029 Winner selection SHALL be one sub-module, fetch_arb_select (requests + pointer in, grant index out); FSM and datapath stay in the top.

Verification
REQ-030 Single: Request0=1, Address0=0x0000_1234, MemWait=0 -> MemAddress=0x0000_1230, MemRequest=1 one cycle; Line=MemLine, Wait0=0 at t+2.
REQ-031 Simultaneous, macro undefined: both request 0x100/0x200 repeatedly -> grants 0,0,0...; requester 1 starves while Request0 held.
REQ-032 Simultaneous, macro defined: both held -> grant sequence 0,1,0,1; MemAddress alternates 0x100/0x200.
REQ-033 Busy downstream: MemWait=1 for 5 cycles in BUSY -> MemRequest stays 1, Wait0=1 throughout; completes cycle after MemWait falls.
REQ-034 Abort/reset: Request1 dropped in BUSY -> Line still updated, Wait1=0; reset=1 in BUSY -> IDLE, MemRequest=0, Line=0 next cycle.
REQ-035 Blocked issue: MemWait=1 in IDLE with Request0=1 -> no MemRequest until MemWait=0.
